// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host-side handshake and status bundle for uart_tx_fifo
//
// Signals:
//   trmt       host -> tx  one-cycle strobe, pushes tx_data into the FIFO
//   tx_data    host -> tx  word to transmit, DATA_BITS wide
//   TX         tx -> host  serial line, idles high
//   tx_busy    tx -> host  frame on the line
//   tx_done    tx -> host  FIFO fully drained, held until the next frame starts
//   fifo_full  tx -> host  FIFO holds FIFO_DEPTH entries
//   fifo_empty tx -> host  FIFO holds no entries
//   tx_ovf     tx -> host  one-cycle pulse after a push was dropped
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 trmt;
    logic [DATA_BITS-1:0] tx_data;
    logic                 TX;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 tx_ovf;

    modport master (
        output trmt, tx_data,
        input  TX, tx_busy, tx_done, fifo_full, fifo_empty, tx_ovf
    );

    modport slave (
        input  trmt, tx_data,
        output TX, tx_busy, tx_done, fifo_full, fifo_empty, tx_ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised UART transmitter with a small transmit FIFO
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_fifo_if.slave: trmt/tx_data in; TX, tx_busy, tx_done,
//          fifo_full, fifo_empty, tx_ovf out
//
// Frames are start, DATA_BITS data (LSB first), optional parity, STOP_BITS
// stop bits, each bit held CLK_DIV clocks. Queued words drain back-to-back.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_fifo_if.slave   bus
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [AW:0]          count_nxt;
    logic                 full_r;
    logic                 empty_r;
    logic                 ovf_r;
    logic                 push;
    logic                 pop;

    // full_r is the registered flag, so a same-cycle pop never frees a slot
    // for the push arriving with it.
    assign push      = bus.trmt & ~full_r;
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            ovf_r   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_nxt;
            full_r  <= (count_nxt == (AW+1)'(FIFO_DEPTH));
            empty_r <= (count_nxt == '0);
            ovf_r   <= bus.trmt & full_r;
        end
    end

    // ------------------------------------------------------------ framer
    state_t               state, state_nxt;
    logic [15:0]          baud_cnt, baud_nxt;
    logic [3:0]           bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 par_bit, par_nxt;
    logic                 tx_r, tx_nxt;
    logic                 busy_r, busy_nxt;
    logic                 done_r, done_nxt;
    logic                 bit_end;
    logic [DATA_BITS-1:0] head;

    assign head    = mem[rd_ptr];
    assign bit_end = (baud_cnt == 16'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            par_bit  <= par_nxt;
            tx_r     <= tx_nxt;
            busy_r   <= busy_nxt;
            done_r   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        par_nxt   = par_bit;
        tx_nxt    = tx_r;
        busy_nxt  = busy_r;
        done_nxt  = done_r;
        pop       = 1'b0;

        if (state != IDLE) begin
            baud_nxt = bit_end ? 16'd0 : baud_cnt + 16'd1;
        end

        case (state)
            IDLE: begin
                if (!empty_r) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    par_nxt   = (^head) ^ 1'(PARITY_ODD);
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_nxt    = shift[0];
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        // bit_cnt is reused to count stop bits
                        bit_nxt = '0;
                        if (PARITY_EN != 0) begin
                            tx_nxt    = par_bit;
                            state_nxt = PARITY;
                        end else begin
                            tx_nxt    = 1'b1;
                            state_nxt = STOP;
                        end
                    end else begin
                        bit_nxt   = bit_cnt + 4'd1;
                        shift_nxt = {1'b0, shift[DATA_BITS-1:1]};
                        tx_nxt    = shift[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    bit_nxt   = '0;
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        if (!empty_r) begin
                            // next start bit follows the stop bit with no gap
                            pop       = 1'b1;
                            shift_nxt = head;
                            par_nxt   = (^head) ^ 1'(PARITY_ODD);
                            baud_nxt  = '0;
                            bit_nxt   = '0;
                            tx_nxt    = 1'b0;
                            state_nxt = START;
                        end else begin
                            tx_nxt    = 1'b1;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.TX         = tx_r;
    assign bus.tx_busy    = busy_r;
    assign bus.tx_done    = done_r;
    assign bus.fifo_full  = full_r;
    assign bus.fifo_empty = empty_r;
    assign bus.tx_ovf     = ovf_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: 8N1 div16, 1: even parity div16, 2: odd parity div16, 3: 7 bits 2 stop div8
    uart_tx_fifo_if #(.DATA_BITS(8)) d_if ();
    uart_tx_fifo_if #(.DATA_BITS(8)) pe_if ();
    uart_tx_fifo_if #(.DATA_BITS(8)) po_if ();
    uart_tx_fifo_if #(.DATA_BITS(7)) s2_if ();

    uart_tx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4))
        u_d (.clk(clk), .rst_n(rst_n), .bus(d_if));
    uart_tx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4))
        u_pe (.clk(clk), .rst_n(rst_n), .bus(pe_if));
    uart_tx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4))
        u_po (.clk(clk), .rst_n(rst_n), .bus(po_if));
    uart_tx_fifo #(.CLK_DIV(8), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4))
        u_s2 (.clk(clk), .rst_n(rst_n), .bus(s2_if));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic en, input logic [7:0] data);
        case (k)
            0: begin d_if.trmt = en;  d_if.tx_data = data;       end
            1: begin pe_if.trmt = en; pe_if.tx_data = data;      end
            2: begin po_if.trmt = en; po_if.tx_data = data;      end
            default: begin s2_if.trmt = en; s2_if.tx_data = data[6:0]; end
        endcase
    endtask

    function automatic logic tx_of(input int k);
        case (k)
            0: return d_if.TX;
            1: return pe_if.TX;
            2: return po_if.TX;
            default: return s2_if.TX;
        endcase
    endfunction

    function automatic logic busy_of(input int k);
        case (k)
            0: return d_if.tx_busy;
            1: return pe_if.tx_busy;
            2: return po_if.tx_busy;
            default: return s2_if.tx_busy;
        endcase
    endfunction

    // Samples each bit at mid-period; 'elapsed' = cycles already spent in the
    // start bit. Returns on the edge that ends the last stop bit.
    task automatic capture(input int k, input int nbits, input int div, input int elapsed,
                           output logic [15:0] bits, output logic busy_last);
        bits      = '0;
        busy_last = 1'b0;
        repeat (div/2 - elapsed) tick();
        for (int i = 0; i < nbits; i++) begin
            bits[i] = tx_of(k);
            if (i == nbits - 1) begin
                repeat (div - div/2 - 1) tick();
                busy_last = busy_of(k);
                tick();
            end else begin
                repeat (div) tick();
            end
        end
    endtask

    logic [15:0] bits;
    logic        busy_last;
    int          low_cnt;

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 4; k++) drive(k, 1'b0, 8'h00);
        tick();
        tick();
        check("rst_TX", d_if.TX, 1);
        check("rst_busy", d_if.tx_busy, 0);
        check("rst_done", d_if.tx_done, 0);
        check("rst_full", d_if.fifo_full, 0);
        check("rst_empty", d_if.fifo_empty, 1);
        check("rst_ovf", d_if.tx_ovf, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // single 0x55 frame, 8N1
        drive(0, 1'b1, 8'h55);
        tick();
        drive(0, 1'b0, 8'hEE);
        check("lat_tx_n1", d_if.TX, 1);
        tick();
        check("lat_tx_n2", d_if.TX, 0);
        check("lat_busy", d_if.tx_busy, 1);
        check("lat_done", d_if.tx_done, 0);
        capture(0, 10, 16, 0, bits, busy_last);
        check("f55_bits", bits, 16'h02AA);
        check("f55_busy_last", busy_last, 1);
        check("f55_end_TX", d_if.TX, 1);
        check("f55_end_busy", d_if.tx_busy, 0);
        check("f55_end_done", d_if.tx_done, 1);

        // even / odd parity on 0x07
        drive(1, 1'b1, 8'h07);
        tick();
        drive(1, 1'b0, 8'h00);
        tick();
        capture(1, 11, 16, 0, bits, busy_last);
        check("par_even_bits", bits, 16'h060E);
        check("par_even_len", busy_last, 1);
        check("par_even_done", pe_if.tx_done, 1);
        drive(2, 1'b1, 8'h07);
        tick();
        drive(2, 1'b0, 8'h00);
        tick();
        capture(2, 11, 16, 0, bits, busy_last);
        check("par_odd_bits", bits, 16'h040E);
        check("par_odd_len", busy_last, 1);
        check("par_odd_done", po_if.tx_done, 1);

        // three back-to-back frames
        drive(0, 1'b1, 8'hA1);
        tick();
        drive(0, 1'b1, 8'hB2);
        tick();
        check("b2b_start", d_if.TX, 0);
        drive(0, 1'b1, 8'hC3);
        tick();
        drive(0, 1'b0, 8'h00);
        capture(0, 10, 16, 1, bits, busy_last);
        check("b2b_A1", bits, 16'h0342);
        check("b2b_gap1_TX", d_if.TX, 0);
        check("b2b_gap1_done", d_if.tx_done, 0);
        capture(0, 10, 16, 0, bits, busy_last);
        check("b2b_B2", bits, 16'h0364);
        check("b2b_gap2_TX", d_if.TX, 0);
        check("b2b_gap2_busy", d_if.tx_busy, 1);
        capture(0, 10, 16, 0, bits, busy_last);
        check("b2b_C3", bits, 16'h0386);
        check("b2b_end_done", d_if.tx_done, 1);
        check("b2b_end_TX", d_if.TX, 1);

        // six pushes: one pops, four fill, sixth overflows
        drive(0, 1'b1, 8'h11);
        tick();
        drive(0, 1'b1, 8'h12);
        tick();
        drive(0, 1'b1, 8'h13);
        tick();
        drive(0, 1'b1, 8'h14);
        tick();
        check("ovf_not_full", d_if.fifo_full, 0);
        drive(0, 1'b1, 8'h15);
        tick();
        check("ovf_full", d_if.fifo_full, 1);
        check("ovf_pre", d_if.tx_ovf, 0);
        drive(0, 1'b1, 8'h16);
        tick();
        drive(0, 1'b0, 8'h00);
        check("ovf_pulse", d_if.tx_ovf, 1);
        tick();
        check("ovf_clear", d_if.tx_ovf, 0);
        capture(0, 10, 16, 5, bits, busy_last);
        check("ovf_f1", bits, 16'h0222);
        capture(0, 10, 16, 0, bits, busy_last);
        check("ovf_f2", bits, 16'h0224);
        capture(0, 10, 16, 0, bits, busy_last);
        check("ovf_f3", bits, 16'h0226);
        capture(0, 10, 16, 0, bits, busy_last);
        check("ovf_f4", bits, 16'h0228);
        capture(0, 10, 16, 0, bits, busy_last);
        check("ovf_f5", bits, 16'h022A);
        check("ovf_end_done", d_if.tx_done, 1);
        check("ovf_end_empty", d_if.fifo_empty, 1);
        low_cnt = 0;
        repeat (40) begin
            tick();
            if (d_if.TX == 1'b0) low_cnt++;
        end
        check("ovf_no_6th", low_cnt, 0);

        // 7 data bits, 2 stop bits
        drive(3, 1'b1, 8'h7F);
        tick();
        drive(3, 1'b0, 8'h00);
        tick();
        capture(3, 10, 8, 0, bits, busy_last);
        check("s2_bits", bits, 16'h03FE);
        check("s2_len", busy_last, 1);
        check("s2_done", s2_if.tx_done, 1);

        // reset mid-frame with two words queued
        drive(0, 1'b1, 8'h00);
        tick();
        drive(0, 1'b1, 8'h33);
        tick();
        drive(0, 1'b1, 8'h44);
        tick();
        drive(0, 1'b0, 8'h00);
        repeat (55) tick();
        check("rstmid_pre_TX", d_if.TX, 0);
        check("rstmid_pre_empty", d_if.fifo_empty, 0);
        rst_n = 1'b0;
        #2;
        check("rstmid_TX", d_if.TX, 1);
        check("rstmid_empty", d_if.fifo_empty, 1);
        check("rstmid_busy", d_if.tx_busy, 0);
        tick();
        rst_n = 1'b1;
        low_cnt = 0;
        repeat (400) begin
            tick();
            if (d_if.TX == 1'b0) low_cnt++;
        end
        check("rstmid_no_frames", low_cnt, 0);
        check("rstmid_post_busy", d_if.tx_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
